// File: rtl/thor2024_pic_pkg.sv
// Shared constants for the thor2024 interrupt controller: register offsets,
// FSM state encoding and the vector width.
package thor2024_pic_pkg;
  localparam int VEC_W = 5;

  localparam logic [2:0] REG_PEND = 3'd0;
  localparam logic [2:0] REG_EN   = 3'd1;
  localparam logic [2:0] REG_EDGE = 3'd2;
  localparam logic [2:0] REG_ISR  = 3'd3;
  localparam logic [2:0] REG_EOI  = 3'd4;
  localparam logic [2:0] REG_RAW  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } pic_state_e;
endpackage

// File: rtl/thor2024_pic_prienc.sv
// Lowest-set-bit finder; the lowest index wins.
module thor2024_pic_prienc
  import thor2024_pic_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]     bits,
  output logic             found,
  output logic [VEC_W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bits[i]) begin
        found = 1'b1;
        idx   = VEC_W'(i);
      end
    end
  end
endmodule

// File: rtl/thor2024_pic.sv
// thor2024 programmable interrupt controller with nested in-service tracking.
// Optional edge-mode sources are built when THOR2024_PIC_EDGE_EN is defined.
module thor2024_pic
  import thor2024_pic_pkg::*;
#(
  parameter int          NSRC     = 32,
  parameter logic [31:0] PIC_ADDR = 32'hFEE50000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [7:0]       sel_i,
  input  logic [31:0]      adr_i,
  input  logic [63:0]      dat_i,
  output logic [63:0]      dat_o,
  output logic             ack_o,
  input  logic [NSRC-1:0]  irq_i,
  output logic             irq_o,
  output logic [VEC_W-1:0] vec_o,
  input  logic             iack_i
);
  logic [NSRC-1:0] sync1, sync2, sync2_d, rise;
  logic [NSRC-1:0] pend, pend_nxt, pend_clr, en, edge_q, isr, pe;
  logic [NSRC-1:0] iack_mask, eoi_mask, wdat, wmask;
  logic [31:0]     bmask;
  logic [63:0]     rd;
  logic [2:0]      reg_sel;
  logic            cs, hit, wr, eoi_wr;
  logic            cand_vld, isr_vld, take, latch;
  logic [VEC_W-1:0] cand_idx, isr_idx;
  pic_state_e      state, state_nxt;
  logic            unused_bits;

  assign unused_bits = ^{adr_i, dat_i, sel_i};

  // Bus decode; writes land only in the ack cycle.
  assign cs      = adr_i[31:12] == PIC_ADDR[31:12];
  assign hit     = cyc_i & stb_i & cs;
  assign wr      = hit & we_i & ack_o;
  assign reg_sel = adr_i[5:3];
  assign eoi_wr  = wr && reg_sel == REG_EOI && sel_i[0];

  always_comb begin
    for (int b = 0; b < 4; b++) bmask[b*8 +: 8] = {8{sel_i[b]}};
  end
  assign wmask = bmask[NSRC-1:0];
  assign wdat  = dat_i[NSRC-1:0] & wmask;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_d <= '0;
    end else begin
      sync1   <= irq_i;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end
  assign rise = sync2 & ~sync2_d;

`ifdef THOR2024_PIC_EDGE_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) edge_q <= '0;
    else if (wr && reg_sel == REG_EDGE) edge_q <= (edge_q & ~wmask) | wdat;
  end
`else
  assign edge_q = '0;
`endif

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      iack_mask[i] = take && (vec_o == VEC_W'(i));
      eoi_mask[i]  = eoi_wr && (dat_i[VEC_W-1:0] == VEC_W'(i));
    end
  end

  // Edge bits: a new rising edge beats any clear arriving in the same cycle.
  assign pend_clr = ((wr && reg_sel == REG_PEND) ? wdat : '0) | iack_mask;
  assign pend_nxt = (edge_q & ((pend & ~pend_clr) | rise)) | (~edge_q & sync2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend <= '0;
      en   <= '0;
      isr  <= '0;
    end else begin
      pend <= pend_nxt;
      if (wr && reg_sel == REG_EN) en <= (en & ~wmask) | wdat;
      isr <= (isr & ~eoi_mask) | iack_mask;
    end
  end

  assign pe = pend & en;

  thor2024_pic_prienc #(.N(NSRC)) u_cand (.bits(pe),  .found(cand_vld), .idx(cand_idx));
  thor2024_pic_prienc #(.N(NSRC)) u_isr  (.bits(isr), .found(isr_vld),  .idx(isr_idx));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cand_vld && (!isr_vld || cand_idx < isr_idx)) state_nxt = REQ;
      REQ:  if (iack_i || !pe[vec_o]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    irq_o = state == REQ;
    take  = (state == REQ) && iack_i;
    latch = (state == IDLE) && (state_nxt == REQ);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    vec_o <= '0;
    else if (latch) vec_o <= cand_idx;
  end

  always_comb begin
    rd = '0;
    case (reg_sel)
      REG_PEND: rd[NSRC-1:0] = pend;
      REG_EN:   rd[NSRC-1:0] = en;
      REG_EDGE: rd[NSRC-1:0] = edge_q;
      REG_ISR:  rd[NSRC-1:0] = isr;
      REG_RAW:  rd[NSRC-1:0] = sync2;
      default:  rd = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= hit;
      dat_o <= hit ? rd : '0;
    end
  end
endmodule

// File: tb/tb_thor2024_pic.sv
// Directed bench for thor2024_pic: bus registers, priority nesting, EOI,
// withdrawal, reset and (when THOR2024_PIC_EDGE_EN is defined) edge sources.
module tb_thor2024_pic;
  localparam logic [31:0] BASE = 32'hFEE50000;

  logic        clk_i = 1'b0, rst_ni = 1'b1;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, iack_i = 1'b0;
  logic [7:0]  sel_i = 8'hFF;
  logic [31:0] adr_i = BASE;
  logic [63:0] dat_i = '0;
  logic [31:0] irq_i = '0;
  logic [63:0] dat_o;
  logic        ack_o, irq_o;
  logic [4:0]  vec_o;
  int          pass_cnt = 0, total_cnt = 0;
  logic [63:0] rdv;

  thor2024_pic dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .irq_i(irq_i), .irq_o(irq_o), .vec_o(vec_o), .iack_i(iack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] r, input logic [63:0] d);
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = BASE | {26'd0, r, 3'd0}; dat_i = d;
    tick(2);
    cyc_i = 0; stb_i = 0; we_i = 0;
    tick(1);
  endtask

  task automatic bus_rd(input logic [2:0] r, output logic [63:0] d);
    cyc_i = 1; stb_i = 1; we_i = 0; adr_i = BASE | {26'd0, r, 3'd0};
    tick(1);
    d = dat_o;
    cyc_i = 0; stb_i = 0;
    tick(1);
  endtask

  task automatic pulse_iack();
    iack_i = 1; tick(1); iack_i = 0;
  endtask

  task automatic test_reset();
    #2 rst_ni = 0;
    #1;
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL rst_irq got %0b want 0", irq_o); else pass_cnt++;
    total_cnt++; if (vec_o !== 5'd0) $display("FAIL rst_vec got %0d want 0", vec_o); else pass_cnt++;
    total_cnt++; if ({ack_o, dat_o} !== 65'd0) $display("FAIL rst_bus got %0b/%h want 0/0", ack_o, dat_o); else pass_cnt++;
    tick(2);
    rst_ni = 1;
    tick(1);
    bus_rd(3'd0, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL rst_pend got %h want 0", rdv); else pass_cnt++;
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL rst_isr got %h want 0", rdv); else pass_cnt++;
  endtask

  task automatic test_regs();
    bus_wr(3'd1, 64'hFFFF_FFFF_A5A5_A5A5);
    bus_rd(3'd1, rdv);
    total_cnt++; if (rdv !== 64'hA5A5A5A5) $display("FAIL reg_en got %h want a5a5a5a5", rdv); else pass_cnt++;
    bus_wr(3'd6, 64'hFFFF_FFFF_FFFF_FFFF);
    bus_rd(3'd6, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL reg6 got %h want 0", rdv); else pass_cnt++;
    sel_i = 8'h01;
    bus_wr(3'd1, 64'h0000_FFFF);
    sel_i = 8'hFF;
    bus_rd(3'd1, rdv);
    total_cnt++; if (rdv !== 64'hA5A5A5FF) $display("FAIL reg_bytesel got %h want a5a5a5ff", rdv); else pass_cnt++;
    bus_wr(3'd1, 64'd0);
    cyc_i = 1; stb_i = 1; adr_i = 32'hFEE60000;
    tick(1);
    total_cnt++; if (ack_o !== 1'b0) $display("FAIL reg_decode_miss ack got %0b want 0", ack_o); else pass_cnt++;
    cyc_i = 0; stb_i = 0;
    tick(1);
    bus_wr(3'd2, 64'h20);
    bus_rd(3'd2, rdv);
`ifdef THOR2024_PIC_EDGE_EN
    total_cnt++; if (rdv !== 64'h20) $display("FAIL reg_edge got %h want 20", rdv); else pass_cnt++;
`else
    total_cnt++; if (rdv !== 64'd0) $display("FAIL reg_edge got %h want 0", rdv); else pass_cnt++;
`endif
    bus_wr(3'd2, 64'd0);
  endtask

  task automatic test_level();
    bus_wr(3'd1, 64'h1);
    irq_i[0] = 1;
    tick(3);
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL lvl_e3 irq got %0b want 0", irq_o); else pass_cnt++;
    tick(1);
    total_cnt++; if (irq_o !== 1'b1 || vec_o !== 5'd0) $display("FAIL lvl_e4 irq/vec got %0b/%0d want 1/0", irq_o, vec_o); else pass_cnt++;
    bus_rd(3'd5, rdv);
    total_cnt++; if (rdv !== 64'h1) $display("FAIL lvl_raw got %h want 1", rdv); else pass_cnt++;
    pulse_iack();
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL lvl_iack irq got %0b want 0", irq_o); else pass_cnt++;
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'h1) $display("FAIL lvl_isr got %h want 1", rdv); else pass_cnt++;
    tick(3);
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL lvl_no_rereq irq got %0b want 0", irq_o); else pass_cnt++;
    irq_i[0] = 0;
    tick(4);
    bus_wr(3'd4, 64'd0);
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL lvl_eoi isr got %h want 0", rdv); else pass_cnt++;
    bus_wr(3'd1, 64'd0);
  endtask

  task automatic test_iack_idle();
    pulse_iack();
    tick(1);
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL iack_idle irq got %0b want 0", irq_o); else pass_cnt++;
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL iack_idle isr got %h want 0", rdv); else pass_cnt++;
  endtask

  task automatic test_nesting();
    bus_wr(3'd1, 64'h114);
    irq_i[4] = 1;
    tick(4);
    pulse_iack();
    irq_i[4] = 0;
    tick(4);
    irq_i[8] = 1;
    tick(6);
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL nest_low_blocked irq got %0b want 0", irq_o); else pass_cnt++;
    irq_i[2] = 1;
    tick(4);
    total_cnt++; if (irq_o !== 1'b1 || vec_o !== 5'd2) $display("FAIL nest_preempt irq/vec got %0b/%0d want 1/2", irq_o, vec_o); else pass_cnt++;
    pulse_iack();
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'h14) $display("FAIL nest_isr got %h want 14", rdv); else pass_cnt++;
    irq_i[2] = 0; irq_i[8] = 0;
    tick(4);
    bus_wr(3'd4, 64'd2);
    bus_wr(3'd4, 64'd4);
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL nest_eoi isr got %h want 0", rdv); else pass_cnt++;
    bus_wr(3'd1, 64'd0);
  endtask

  task automatic test_withdraw();
    bus_wr(3'd1, 64'h8);
    irq_i[3] = 1;
    tick(4);
    total_cnt++; if (irq_o !== 1'b1 || vec_o !== 5'd3) $display("FAIL wd_req irq/vec got %0b/%0d want 1/3", irq_o, vec_o); else pass_cnt++;
    irq_i[3] = 0;
    tick(4);
    total_cnt++; if (irq_o !== 1'b0 || vec_o !== 5'd3) $display("FAIL wd_drop irq/vec got %0b/%0d want 0/3", irq_o, vec_o); else pass_cnt++;
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL wd_isr got %h want 0", rdv); else pass_cnt++;
    bus_wr(3'd1, 64'd0);
  endtask

  task automatic test_eoi();
    bus_wr(3'd1, 64'hC);
    irq_i[3] = 1;
    tick(4);
    pulse_iack();
    irq_i[2] = 1;
    tick(4);
    total_cnt++; if (irq_o !== 1'b1 || vec_o !== 5'd2) $display("FAIL eoi_req2 irq/vec got %0b/%0d want 1/2", irq_o, vec_o); else pass_cnt++;
    pulse_iack();
    irq_i[2] = 0; irq_i[3] = 0;
    tick(4);
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'hC) $display("FAIL eoi_setup isr got %h want c", rdv); else pass_cnt++;
    bus_wr(3'd4, 64'd3);
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'h4) $display("FAIL eoi_3 isr got %h want 4", rdv); else pass_cnt++;
    bus_wr(3'd4, 64'd31);
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'h4) $display("FAIL eoi_31 isr got %h want 4", rdv); else pass_cnt++;
    bus_wr(3'd4, 64'd2);
    bus_wr(3'd1, 64'd0);
  endtask

  task automatic test_back_to_back();
    // iack and EOI of the same index land on the same edge.
    bus_wr(3'd1, 64'h2);
    irq_i[1] = 1;
    tick(4);
    total_cnt++; if (irq_o !== 1'b1 || vec_o !== 5'd1) $display("FAIL simul_req irq/vec got %0b/%0d want 1/1", irq_o, vec_o); else pass_cnt++;
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = BASE | 32'h20; dat_i = 64'd1;
    tick(1);
    iack_i = 1;
    tick(1);
    iack_i = 0; cyc_i = 0; stb_i = 0; we_i = 0;
    tick(1);
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'h2) $display("FAIL simul_isr got %h want 2", rdv); else pass_cnt++;
    irq_i[1] = 0;
    tick(4);
    bus_wr(3'd4, 64'd1);
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL simul_eoi isr got %h want 0", rdv); else pass_cnt++;
    bus_wr(3'd1, 64'd0);
  endtask

  task automatic test_edge();
    bus_wr(3'd2, 64'h20);
    bus_wr(3'd1, 64'h20);
    irq_i[5] = 1;
    tick(1);
    irq_i[5] = 0;
`ifdef THOR2024_PIC_EDGE_EN
    tick(5);
    total_cnt++; if (irq_o !== 1'b1 || vec_o !== 5'd5) $display("FAIL edge_req irq/vec got %0b/%0d want 1/5", irq_o, vec_o); else pass_cnt++;
    bus_rd(3'd0, rdv);
    total_cnt++; if (rdv !== 64'h20) $display("FAIL edge_pend_held got %h want 20", rdv); else pass_cnt++;
    pulse_iack();
    bus_rd(3'd0, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL edge_pend_iack got %h want 0", rdv); else pass_cnt++;
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'h20) $display("FAIL edge_isr got %h want 20", rdv); else pass_cnt++;
    bus_wr(3'd4, 64'd5);
    irq_i[5] = 1;
    tick(1);
    irq_i[5] = 0;
    tick(5);
    total_cnt++; if (irq_o !== 1'b1) $display("FAIL edge_req2 irq got %0b want 1", irq_o); else pass_cnt++;
    bus_wr(3'd0, 64'h20);
    tick(1);
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL edge_w1c irq got %0b want 0", irq_o); else pass_cnt++;
    bus_rd(3'd0, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL edge_w1c pend got %h want 0", rdv); else pass_cnt++;
`else
    tick(6);
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL lvlonly_irq got %0b want 0", irq_o); else pass_cnt++;
    bus_rd(3'd0, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL lvlonly_pend got %h want 0", rdv); else pass_cnt++;
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL lvlonly_isr got %h want 0", rdv); else pass_cnt++;
`endif
    bus_wr(3'd2, 64'd0);
    bus_wr(3'd1, 64'd0);
  endtask

  task automatic test_reset_mid();
    bus_wr(3'd1, 64'h40);
    irq_i[6] = 1;
    tick(4);
    total_cnt++; if (irq_o !== 1'b1 || vec_o !== 5'd6) $display("FAIL rmid_req irq/vec got %0b/%0d want 1/6", irq_o, vec_o); else pass_cnt++;
    rst_ni = 0; irq_i[6] = 0;
    #1;
    total_cnt++; if (irq_o !== 1'b0 || vec_o !== 5'd0) $display("FAIL rmid_async irq/vec got %0b/%0d want 0/0", irq_o, vec_o); else pass_cnt++;
    tick(2);
    rst_ni = 1;
    tick(1);
    bus_rd(3'd0, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL rmid_pend got %h want 0", rdv); else pass_cnt++;
    bus_rd(3'd3, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL rmid_isr got %h want 0", rdv); else pass_cnt++;
    bus_rd(3'd1, rdv);
    total_cnt++; if (rdv !== 64'd0) $display("FAIL rmid_en got %h want 0", rdv); else pass_cnt++;
    bus_wr(3'd1, 64'h40);
    irq_i[6] = 1;
    tick(4);
    total_cnt++; if (irq_o !== 1'b1 || vec_o !== 5'd6) $display("FAIL rmid_resume irq/vec got %0b/%0d want 1/6", irq_o, vec_o); else pass_cnt++;
    irq_i[6] = 0;
    tick(4);
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL rmid_idle irq got %0b want 0", irq_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_level();
    test_iack_idle();
    test_nesting();
    test_withdraw();
    test_eoi();
    test_back_to_back();
    test_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after 200000 time units");
    $fatal(1);
  end
endmodule
